cpu_dm_axi_bridge: RTL and testbench
====================================

# cpu_dm_axi_bridge

Data-side AXI master bridge between the `cpu` MEM stage and AXI master port M1. It decodes the load/store in MEM from `opcode_MEM`/`funct3_MEM` and performs one single-beat AXI read or write. It aligns write data and generates WSTRB, returns the read word on `DM_data`, and holds the pipeline via `stall` until the transfer completes.

## Interface
- `ID_W`, default 4: width of ARID/AWID/RID/BID.
- `MASTER_ID`, default 4'd1: constant value driven on ARID_M1/AWID_M1.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; **one clock; reset is asynchronous and active-high**.
- `opcode_MEM`  in  7  MEM-stage opcode. 7'b0000011 = load; 7'b0100011 = store.
- `funct3_MEM`  in  3  access size: 000 = byte, 001 = half, 010 = word.
- `ALU_result_MEM`  in  32  byte address.
- `DM_input`  in  32  store data, right-justified.
- `DM_data`  out  32  last read word, raw and unshifted.
- `stall`  out  1  freezes all pipeline registers while high.
- `resp_err`  out  1  sticky response error (see Configuration).
- `ARID_M1`/`ARADDR_M1`/`ARVALID_M1`  out  ID_W/32/1; `ARREADY_M1`  in  1.
- `ARLEN_M1`, `AWLEN_M1`  out  4  constant 0.
- `ARSIZE_M1`, `AWSIZE_M1`  out  3  constant 3'b010.
- `ARBURST_M1`, `AWBURST_M1`  out  2  constant 2'b01.
- `RID_M1`/`RDATA_M1`/`RRESP_M1`/`RLAST_M1`/`RVALID_M1`  in  ID_W/32/2/1/1; `RREADY_M1`  out  1.
- `AWID_M1`/`AWADDR_M1`/`AWVALID_M1`  out  ID_W/32/1; `AWREADY_M1`  in  1.
- `WDATA_M1`/`WSTRB_M1`/`WLAST_M1`/`WVALID_M1`  out  32/4/1/1; `WREADY_M1`  in  1.
- `BID_M1`/`BRESP_M1`/`BVALID_M1`  in  ID_W/2/1; `BREADY_M1`  out  1.

## Operation
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP, DONE. Reset state is IDLE.
- IDLE:
  - load → RADDR; store → WREQ.
  - Address, funct3 and aligned write data are latched on the IDLE exit edge.
  - Any other opcode stays in IDLE.
- RADDR: ARVALID_M1 = 1, ARADDR_M1 = latched address. On ARREADY → RDATA.
- RDATA: RREADY_M1 = 1. On RVALID, latch RDATA into `DM_data` → DONE. RID and RLAST are ignored.
- WREQ:
  - AWVALID_M1 and WVALID_M1 assert together. Each drops independently after its own handshake; `aw_done`/`w_done` flags track this.
  - Same-cycle AWREADY and WREADY completes both.
  - When both are done → WRESP.
- WRESP: BREADY_M1 = 1. On BVALID → DONE.
- DONE: one cycle, then → IDLE unconditionally. This blocks re-issue of the same MEM instruction while the pipeline advances.
- `stall` = (IDLE & (load | store)) | RADDR | RDATA | WREQ | WRESP. It is combinational on IDLE and low in DONE.
- WSTRB_M1 and WDATA_M1 by size, with a = addr[1:0]:
  - byte: 4'b0001 << a; data << 8·a.
  - half: 4'b0011 << {a[1],0}; data << 16·a[1].
  - word: 4'b1111; data unshifted.
  - Other funct3 values are treated as word.
- WLAST_M1 equals WVALID_M1.
- Misalignment is not checked. The address is passed through unmodified.
- `DM_data` holds its value until the next read completes.

## Timing
- Reset values:
  - All VALID/READY outputs 0.
  - `DM_data` 0, `resp_err` 0.
  - ARADDR/AWADDR/WDATA 0, WSTRB 0.
- Read with zero-wait slave: stall high in cycles c0 (IDLE), c1 (RADDR), c2 (RDATA); low in c3 (DONE). `DM_data` is valid from c3.
- Write with zero-wait slave: stall high in c0, c1 (WREQ), c2 (WRESP); low in c3.
- VALID is registered, and address/data are stable while VALID is high. VALID never drops before READY.
- Asynchronous `rst` mid-transfer forces IDLE immediately and drops all VALID/READY. Protocol abort is accepted because the whole system resets.

## Configuration
- `BRIDGE_RESP_ERR_EN` defined:
  - `resp_err` sets to 1 on an R handshake with RRESP ≠ 0 or a B handshake with BRESP ≠ 0.
  - It clears only on reset.
  - The transfer still completes normally.
- Not defined: `resp_err` is constant 0 and no capture logic is built.

## Test plan
- Load word, addr 0x0000_1004, slave ARREADY at c1 and RVALID at c2 with 0xDEADBEEF → ARADDR 0x1004, stall high c0–c2, DM_data 0xDEADBEEF at c3.
- Store byte, addr 0x0000_2003, DM_input 0x0000_00A5 → WSTRB 4'b1000, WDATA 0xA500_0000, AWADDR 0x2003.
- Store half, addr 0x0000_2002, DM_input 0x1234; AWREADY at c1, WREADY delayed to c4 → WSTRB 4'b1100, WDATA 0x1234_0000; AWVALID drops after c1 while WVALID holds until c4; DONE reached after BVALID.
- Back-to-back loads, MEM opcode still load in DONE → exactly one AR per instruction; the second AR issues only after re-entering IDLE with the new instruction.
- Reset asserted during RDATA with RVALID low → next cycle all VALID/READY 0, stall low, DM_data 0.
- With `BRIDGE_RESP_ERR_EN`: BRESP = 2'b10 on a store → resp_err 1 and it stays 1 across later OKAY transfers. Without the macro, resp_err stays 0.

Source files
------------

// File: rtl/cpu_dm_axi_bridge.sv
// Data-side AXI master bridge: one single-beat read or write per MEM-stage load/store.
// Optional sticky response-error capture is enabled by defining BRIDGE_RESP_ERR_EN.
module cpu_dm_axi_bridge #(
    parameter int unsigned      ID_W      = 4,
    parameter logic [ID_W-1:0]  MASTER_ID = 4'd1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      opcode_MEM,
    input  logic [2:0]      funct3_MEM,
    input  logic [31:0]     ALU_result_MEM,
    input  logic [31:0]     DM_input,
    output logic [31:0]     DM_data,
    output logic            stall,
    output logic            resp_err,
    output logic [ID_W-1:0] ARID_M1,
    output logic [31:0]     ARADDR_M1,
    output logic [3:0]      ARLEN_M1,
    output logic [2:0]      ARSIZE_M1,
    output logic [1:0]      ARBURST_M1,
    output logic            ARVALID_M1,
    input  logic            ARREADY_M1,
    input  logic [ID_W-1:0] RID_M1,
    input  logic [31:0]     RDATA_M1,
    input  logic [1:0]      RRESP_M1,
    input  logic            RLAST_M1,
    input  logic            RVALID_M1,
    output logic            RREADY_M1,
    output logic [ID_W-1:0] AWID_M1,
    output logic [31:0]     AWADDR_M1,
    output logic [3:0]      AWLEN_M1,
    output logic [2:0]      AWSIZE_M1,
    output logic [1:0]      AWBURST_M1,
    output logic            AWVALID_M1,
    input  logic            AWREADY_M1,
    output logic [31:0]     WDATA_M1,
    output logic [3:0]      WSTRB_M1,
    output logic            WLAST_M1,
    output logic            WVALID_M1,
    input  logic            WREADY_M1,
    input  logic [ID_W-1:0] BID_M1,
    input  logic [1:0]      BRESP_M1,
    input  logic            BVALID_M1,
    output logic            BREADY_M1
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RADDR = 3'd1;
    localparam logic [2:0] RDATA = 3'd2;
    localparam logic [2:0] WREQ  = 3'd3;
    localparam logic [2:0] WRESP = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] dm_data_q, dm_data_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;

    logic        is_load, is_store;
    logic [1:0]  a;
    logic [3:0]  strb_new;
    logic [31:0] data_new;

    assign is_load  = (opcode_MEM == 7'b0000011);
    assign is_store = (opcode_MEM == 7'b0100011);
    assign a        = ALU_result_MEM[1:0];

    // Align store data and build byte strobes from size and low address bits
    always_comb begin
        strb_new = 4'b1111;
        data_new = DM_input;
        unique case (funct3_MEM)
            3'b000: begin
                strb_new = 4'b0001 << a;
                data_new = DM_input << {a, 3'b000};
            end
            3'b001: begin
                strb_new = 4'b0011 << {a[1], 1'b0};
                data_new = DM_input << {a[1], 4'b0000};
            end
            default: begin
                strb_new = 4'b1111;
                data_new = DM_input;
            end
        endcase
    end

    // Transfer sequencing; VALID/READY flops follow the next state
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        dm_data_d = dm_data_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            IDLE: begin
                if (is_load || is_store) begin
                    state_d = is_load ? RADDR : WREQ;
                    addr_d  = ALU_result_MEM;
                    wdata_d = data_new;
                    wstrb_d = strb_new;
                end
            end
            RADDR: begin
                if (ARREADY_M1) state_d = RDATA;
            end
            RDATA: begin
                if (RVALID_M1) begin
                    dm_data_d = RDATA_M1;
                    state_d   = DONE;
                end
            end
            WREQ: begin
                aw_done_d = aw_done_q | (awvalid_q & AWREADY_M1);
                w_done_d  = w_done_q | (wvalid_q & WREADY_M1);
                if (aw_done_d && w_done_d) begin
                    state_d   = WRESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WRESP: begin
                if (BVALID_M1) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        arvalid_d = (state_d == RADDR);
        rready_d  = (state_d == RDATA);
        awvalid_d = (state_d == WREQ) & ~aw_done_d;
        wvalid_d  = (state_d == WREQ) & ~w_done_d;
        bready_d  = (state_d == WRESP);
    end

    // State and channel registers; reset aborts any transfer immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            dm_data_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            dm_data_q <= dm_data_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

`ifdef BRIDGE_RESP_ERR_EN
    logic resp_err_q, resp_err_d;

    // Sticky error on any non-OKAY read or write response
    always_comb begin
        resp_err_d = resp_err_q;
        if (rready_q && RVALID_M1 && (RRESP_M1 != 2'b00)) resp_err_d = 1'b1;
        if (bready_q && BVALID_M1 && (BRESP_M1 != 2'b00)) resp_err_d = 1'b1;
    end

    // Error flag clears only on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) resp_err_q <= 1'b0;
        else     resp_err_q <= resp_err_d;
    end

    assign resp_err = resp_err_q;

    logic unused_sigs;
    assign unused_sigs = ^{RID_M1, RLAST_M1, BID_M1};
`else
    assign resp_err = 1'b0;

    logic unused_sigs;
    assign unused_sigs = ^{RID_M1, RLAST_M1, BID_M1, RRESP_M1, BRESP_M1};
`endif

    assign stall = ((state_q == IDLE) & (is_load | is_store))
                 | (state_q == RADDR) | (state_q == RDATA)
                 | (state_q == WREQ)  | (state_q == WRESP);

    assign DM_data    = dm_data_q;
    assign ARID_M1    = MASTER_ID;
    assign ARADDR_M1  = addr_q;
    assign ARLEN_M1   = 4'd0;
    assign ARSIZE_M1  = 3'b010;
    assign ARBURST_M1 = 2'b01;
    assign ARVALID_M1 = arvalid_q;
    assign RREADY_M1  = rready_q;
    assign AWID_M1    = MASTER_ID;
    assign AWADDR_M1  = addr_q;
    assign AWLEN_M1   = 4'd0;
    assign AWSIZE_M1  = 3'b010;
    assign AWBURST_M1 = 2'b01;
    assign AWVALID_M1 = awvalid_q;
    assign WDATA_M1   = wdata_q;
    assign WSTRB_M1   = wstrb_q;
    assign WVALID_M1  = wvalid_q;
    assign WLAST_M1   = wvalid_q;
    assign BREADY_M1  = bready_q;

endmodule

// File: tb/tb_cpu_dm_axi_bridge.sv
// Directed bench for cpu_dm_axi_bridge: loads, stores, back-to-back issue,
// response error flag and asynchronous reset mid-transfer.
module tb_cpu_dm_axi_bridge;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_NOP = 7'b0010011;
`ifdef BRIDGE_RESP_ERR_EN
    localparam logic [31:0] ERR_EXP = 32'd1;
`else
    localparam logic [31:0] ERR_EXP = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode_MEM;
    logic [2:0]  funct3_MEM;
    logic [31:0] ALU_result_MEM;
    logic [31:0] DM_input;
    logic [31:0] DM_data;
    logic        stall;
    logic        resp_err;
    logic [3:0]  ARID_M1, AWID_M1, RID_M1, BID_M1;
    logic [31:0] ARADDR_M1, AWADDR_M1, RDATA_M1, WDATA_M1;
    logic [3:0]  ARLEN_M1, AWLEN_M1, WSTRB_M1;
    logic [2:0]  ARSIZE_M1, AWSIZE_M1;
    logic [1:0]  ARBURST_M1, AWBURST_M1, RRESP_M1, BRESP_M1;
    logic        ARVALID_M1, ARREADY_M1, RLAST_M1, RVALID_M1, RREADY_M1;
    logic        AWVALID_M1, AWREADY_M1, WLAST_M1, WVALID_M1, WREADY_M1;
    logic        BVALID_M1, BREADY_M1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_dm_axi_bridge dut (
        .clk(clk), .rst(rst),
        .opcode_MEM(opcode_MEM), .funct3_MEM(funct3_MEM),
        .ALU_result_MEM(ALU_result_MEM), .DM_input(DM_input),
        .DM_data(DM_data), .stall(stall), .resp_err(resp_err),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1),
        .ARSIZE_M1(ARSIZE_M1), .ARBURST_M1(ARBURST_M1),
        .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
        .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1),
        .RLAST_M1(RLAST_M1), .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
        .AWID_M1(AWID_M1), .AWADDR_M1(AWADDR_M1), .AWLEN_M1(AWLEN_M1),
        .AWSIZE_M1(AWSIZE_M1), .AWBURST_M1(AWBURST_M1),
        .AWVALID_M1(AWVALID_M1), .AWREADY_M1(AWREADY_M1),
        .WDATA_M1(WDATA_M1), .WSTRB_M1(WSTRB_M1), .WLAST_M1(WLAST_M1),
        .WVALID_M1(WVALID_M1), .WREADY_M1(WREADY_M1),
        .BID_M1(BID_M1), .BRESP_M1(BRESP_M1), .BVALID_M1(BVALID_M1),
        .BREADY_M1(BREADY_M1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic slv_idle();
        ARREADY_M1 = 0; RVALID_M1 = 0; RDATA_M1 = 0; RRESP_M1 = 0;
        RID_M1 = 4'd1; RLAST_M1 = 1;
        AWREADY_M1 = 0; WREADY_M1 = 0;
        BVALID_M1 = 0; BRESP_M1 = 0; BID_M1 = 4'd1;
    endtask

    task automatic mem(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] ad, input logic [31:0] d);
        opcode_MEM = op; funct3_MEM = f3; ALU_result_MEM = ad; DM_input = d;
    endtask

    // each cycle: drive at negedge, check 1ns later
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic valids(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, ARVALID_M1, RREADY_M1, AWVALID_M1, WVALID_M1,
                  BREADY_M1}, {27'd0, exp});
    endtask

    initial begin
        rst = 1;
        slv_idle();
        mem(OP_NOP, 3'b010, 0, 0);
        #12;
        chk("rst_valids", {27'd0, ARVALID_M1, RREADY_M1, AWVALID_M1,
            WVALID_M1, BREADY_M1}, 0);
        chk("rst_dm", DM_data, 0);
        chk("rst_err", {31'd0, resp_err}, 0);
        chk("rst_addr", ARADDR_M1 | AWADDR_M1 | WDATA_M1, 0);
        chk("rst_strb", {28'd0, WSTRB_M1}, 0);
        cyc(); rst = 0;

        // load word 0x1004, zero-wait slave
        cyc(); mem(OP_LD, 3'b010, 32'h1004, 0); #1;
        chk("ld_c0_stall", {31'd0, stall}, 1);
        valids("ld_c0_v", 5'b00000);
        cyc(); ARREADY_M1 = 1; #1;
        valids("ld_c1_v", 5'b10000);
        chk("ld_araddr", ARADDR_M1, 32'h1004);
        chk("ld_c1_stall", {31'd0, stall}, 1);
        chk("ld_arconst", {ARID_M1, ARLEN_M1, 1'b0, ARSIZE_M1, 2'b0,
            ARBURST_M1}, {4'd1, 4'd0, 4'b0010, 4'b0001});
        cyc(); ARREADY_M1 = 0; RVALID_M1 = 1; RDATA_M1 = 32'hDEADBEEF; #1;
        valids("ld_c2_v", 5'b01000);
        chk("ld_c2_stall", {31'd0, stall}, 1);
        // DONE while MEM already holds the next load
        cyc(); slv_idle(); mem(OP_LD, 3'b010, 32'h1008, 0); #1;
        chk("ld_c3_stall", {31'd0, stall}, 0);
        chk("ld_dm", DM_data, 32'hDEADBEEF);
        valids("ld_c3_v", 5'b00000);
        cyc(); #1;
        valids("b2b_c4_v", 5'b00000);
        chk("b2b_c4_stall", {31'd0, stall}, 1);
        cyc(); ARREADY_M1 = 1; #1;
        valids("b2b_c5_v", 5'b10000);
        chk("b2b_araddr", ARADDR_M1, 32'h1008);
        cyc(); ARREADY_M1 = 0; RVALID_M1 = 1; RDATA_M1 = 32'h11223344; #1;
        cyc(); slv_idle(); mem(OP_NOP, 3'b010, 0, 0); #1;
        chk("b2b_dm", DM_data, 32'h11223344);
        cyc(); #1;
        valids("b2b_idle_v", 5'b00000);
        chk("b2b_dm_hold", DM_data, 32'h11223344);

        // store byte 0x2003 <- A5
        cyc(); mem(OP_ST, 3'b000, 32'h2003, 32'h000000A5); #1;
        chk("sb_c0_stall", {31'd0, stall}, 1);
        cyc(); AWREADY_M1 = 1; WREADY_M1 = 1; #1;
        valids("sb_c1_v", 5'b00110);
        chk("sb_wlast", {31'd0, WLAST_M1}, 1);
        chk("sb_awaddr", AWADDR_M1, 32'h2003);
        chk("sb_wstrb", {28'd0, WSTRB_M1}, 32'h8);
        chk("sb_wdata", WDATA_M1, 32'hA5000000);
        cyc(); slv_idle(); BVALID_M1 = 1; #1;
        valids("sb_c2_v", 5'b00001);
        chk("sb_c2_stall", {31'd0, stall}, 1);
        cyc(); slv_idle(); mem(OP_NOP, 3'b010, 0, 0); #1;
        chk("sb_c3_stall", {31'd0, stall}, 0);
        chk("sb_err", {31'd0, resp_err}, 0);

        // store half 0x2002 <- 1234, W delayed, BRESP SLVERR
        cyc(); mem(OP_ST, 3'b001, 32'h2002, 32'h00001234); #1;
        cyc(); AWREADY_M1 = 1; #1;
        valids("sh_c1_v", 5'b00110);
        cyc(); AWREADY_M1 = 0; #1;
        valids("sh_c2_v", 5'b00010);
        chk("sh_c2_stall", {31'd0, stall}, 1);
        cyc(); #1;
        valids("sh_c3_v", 5'b00010);
        cyc(); WREADY_M1 = 1; #1;
        valids("sh_c4_v", 5'b00010);
        chk("sh_wstrb", {28'd0, WSTRB_M1}, 32'hC);
        chk("sh_wdata", WDATA_M1, 32'h12340000);
        chk("sh_wlast", {31'd0, WLAST_M1}, 1);
        cyc(); WREADY_M1 = 0; #1;
        valids("sh_c5_v", 5'b00001);
        cyc(); #1;
        chk("sh_wait_stall", {31'd0, stall}, 1);
        BVALID_M1 = 1; BRESP_M1 = 2'b10;
        cyc(); slv_idle(); mem(OP_NOP, 3'b010, 0, 0); #1;
        chk("sh_done_stall", {31'd0, stall}, 0);
        chk("sh_err", {31'd0, resp_err}, ERR_EXP);

        // OKAY load: error flag must persist
        cyc(); mem(OP_LD, 3'b010, 32'h3000, 0);
        cyc(); ARREADY_M1 = 1;
        cyc(); ARREADY_M1 = 0; RVALID_M1 = 1; RDATA_M1 = 32'hCAFEF00D;
        cyc(); slv_idle(); mem(OP_NOP, 3'b010, 0, 0); #1;
        chk("ok_dm", DM_data, 32'hCAFEF00D);
        chk("err_sticky", {31'd0, resp_err}, ERR_EXP);

        // reset during RDATA with RVALID low
        cyc(); mem(OP_LD, 3'b010, 32'h4000, 0);
        cyc(); ARREADY_M1 = 1;
        cyc(); ARREADY_M1 = 0; #1;
        valids("rr_pre_v", 5'b01000);
        rst = 1; mem(OP_NOP, 3'b010, 0, 0); #1;
        valids("rr_async_v", 5'b00000);
        cyc(); #1;
        valids("rr_v", 5'b00000);
        chk("rr_stall", {31'd0, stall}, 0);
        chk("rr_dm", DM_data, 0);
        chk("rr_err", {31'd0, resp_err}, 0);
        rst = 0;
        cyc(); #1;
        valids("rr_after_v", 5'b00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
